golden_nonce_fifo: RTL and testbench
====================================

// Module: golden_nonce_fifo
// PURPOSE
//  Downstream of the hash/target comparator stage: captures every candidate flagged hash<=target
//  together with the nonce that produced it, and buffers it in a small FIFO.
//  Presents results to the host/readout logic over a valid/ready handshake.
//  Keeps saturating hit/drop statistics so firmware can detect lost shares.
// PARAMETERS
//  HASH_W   256  width of captured hash
//  NONCE_W  32   width of nonce tag
//  DEPTH    4    FIFO entries; power of two, >=2
//  CNT_W    16   width of hit_count / drop_count
// PORTS
//  clk         in   1                   single clock; all logic rising-edge
//  rst_n       in   1                   synchronous, active-low reset
//  clear       in   1                   sync flush: empty FIFO, zero counters and overflow
//  cmp_valid   in   1                   comparator result valid this cycle (one candidate)
//  cmp_hit     in   1                   1 = hash<=target; ignored when cmp_valid=0
//  cmp_hash    in   HASH_W              hash of candidate
//  cmp_nonce   in   NONCE_W             nonce of candidate
//  res_valid   out  1                   head entry available
//  res_ready   in   1                   consumer accepts head when res_valid=1
//  res_nonce   out  NONCE_W             head nonce
//  res_hash    out  HASH_W              head hash
//  res_level   out  $clog2(DEPTH)+1     current occupancy 0..DEPTH
//  hit_count   out  CNT_W               hits seen (accepted + dropped), saturating
//  drop_count  out  CNT_W               hits dropped due to full FIFO, saturating
//  overflow    out  1                   sticky; set on first drop
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pointers, level, counters, overflow = 0; storage = 0;
//    res_valid=0, res_nonce=0, res_hash=0. rst_n dominates clear and all inputs.
//  - push = cmp_valid & cmp_hit & ~clear; pop = res_valid & res_ready & ~clear.
//  - Push accepted if level<DEPTH, or level==DEPTH and pop in same cycle (slot freed).
//  - Full and no pop: candidate dropped; drop_count+1 (saturate at all-ones); overflow<=1.
//  - hit_count +1 on every push attempt (accepted or dropped); saturates at all-ones.
//  - Latency: push into empty FIFO at edge N -> res_valid=1 and data visible after edge N.
//    No combinational bypass from cmp_* to res_*.
//  - res_nonce/res_hash = storage[rd_ptr]; held stable while res_valid & ~res_ready.
//  - Pop at edge advances rd_ptr; next entry (if any) is visible the following cycle.
//  - Simultaneous push+pop when empty: pop impossible (res_valid=0); push only.
//  - Simultaneous push+pop when 0<level<DEPTH: level unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; empty = ptrs equal,
//    full = MSB differs and remaining bits equal.
//  - clear=1: next cycle level=0, res_valid=0, counters=0, overflow=0; same-cycle
//    candidate discarded and not counted. Storage contents not cleared.
//  - Reset or clear mid-handshake: entry is lost; consumer must not assume delivery.
//  - X on cmp_hash/cmp_nonce when no push must not propagate into state.
// STRUCTURE
//  - Shared package miner_pkg: HASH_W, NONCE_W constants; typedef struct packed
//    {nonce, hash} result_t, used by comparator, this block, and readout.
//  - One sub-module: sat_counter #(CNT_W) (sync active-low reset, clr, inc, saturates);
//    instantiated twice, for hit_count and drop_count.
//  - FIFO storage: flat register array of result_t, DEPTH entries; no SRAM macro.
// TESTING
//  1 Reset: drive rst_n=0 for 2 cycles with cmp_valid=1 -> all outputs 0, level=0.
//  2 Single hit: cmp_valid=1,cmp_hit=1,nonce=0xDEADBEEF,hash=0x0..01, ready=0 ->
//    next cycle res_valid=1, res_nonce=0xDEADBEEF; held until ready=1; then valid=0.
//  3 Miss filtering: 10 cycles cmp_valid=1,cmp_hit=0, plus cmp_hit=1 with
//    cmp_valid=0 -> level stays 0, hit_count=0.
//  4 Overflow: 6 hits (nonces 1..6), ready=0 -> level=4, drop_count=2, hit_count=6,
//    overflow=1; drain -> order 1,2,3,4.
//  5 Full push+pop: level=4, ready=1 and hit nonce=9 same cycle -> level stays 4,
//    no drop; drained order continues with nonce 9 last.
//  6 Clear/saturation: preset CNT_W=4, 20 hits with ready=1 -> hit_count=15;
//    then clear with a hit -> all counters 0, level 0, res_valid=0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared mining-datapath types: candidate hash/nonce widths and the packed result
// record that the comparator, golden-nonce FIFO and readout logic all exchange.
package miner_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } result_t;

endpackage

// File: rtl/golden_nonce_fifo_if.sv
// Candidate-in / result-out handshake bundle of the golden-nonce FIFO.
// The slave view is the FIFO itself; the master view is its surrounding logic.
interface golden_nonce_fifo_if;
  import miner_pkg::*;

  logic               cmp_valid;
  logic               cmp_hit;
  logic [HASH_W-1:0]  cmp_hash;
  logic [NONCE_W-1:0] cmp_nonce;

  logic               res_valid;
  logic               res_ready;
  logic [NONCE_W-1:0] res_nonce;
  logic [HASH_W-1:0]  res_hash;

  modport master (
    output cmp_valid, cmp_hit, cmp_hash, cmp_nonce, res_ready,
    input  res_valid, res_nonce, res_hash
  );

  modport slave (
    input  cmp_valid, cmp_hit, cmp_hash, cmp_nonce, res_ready,
    output res_valid, res_nonce, res_hash
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear;
// sticks at all-ones so firmware can tell a wrapped statistic from a real one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: reset and clear dominate, increment stops at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/golden_nonce_fifo.sv
// Golden-nonce capture FIFO: buffers comparator hits (nonce + hash) for the readout
// logic over valid/ready and keeps saturating hit/drop statistics.
module golden_nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  golden_nonce_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] res_level,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] level_r;
  logic          overflow_r;
  result_t       mem_r [DEPTH];

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          accept_s;
  logic          drop_s;
  result_t       wr_data_s;

  // Occupancy flags; the extra pointer bit separates full from empty
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
              (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  end

  // Handshake qualification; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    push_s          = bus.cmp_valid & bus.cmp_hit & ~clear;
    pop_s           = ~empty_s & bus.res_ready & ~clear;
    accept_s        = push_s & (~full_s | pop_s);
    drop_s          = push_s & full_s & ~pop_s;
    wr_data_s.nonce = bus.cmp_nonce;
    wr_data_s.hash  = bus.cmp_hash;
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   level_r <= level_r + PW'(1);
        2'b01:   level_r <= level_r - PW'(1);
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Entry storage; only written on an accepted push so idle-bus X never lands in state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
    end else begin
      mem_r <= mem_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (push_s),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (drop_s),
    .count (drop_count)
  );

  assign bus.res_valid = ~empty_s;
  assign bus.res_nonce = mem_r[rd_ptr_r[AW-1:0]].nonce;
  assign bus.res_hash  = mem_r[rd_ptr_r[AW-1:0]].hash;
  assign res_level     = level_r;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Directed bench for golden_nonce_fifo: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_golden_nonce_fifo;
  import miner_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   clear;
  logic [$clog2(DEPTH):0] res_level;
  logic [CNT_W-1:0]       hit_count;
  logic [CNT_W-1:0]       drop_count;
  logic                   overflow;

  int n_checks = 0;
  int n_fail   = 0;

  golden_nonce_fifo_if bus ();

  golden_nonce_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .res_level  (res_level),
    .hit_count  (hit_count),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkh(input logic [31:0] n);
    return {n, 192'h0, ~n};
  endfunction

  // Inputs change on the falling edge; outputs are read back at the next falling edge
  task automatic step(input logic v, input logic h, input logic [31:0] n,
                      input logic [255:0] hs, input logic rdy, input logic clr);
    bus.cmp_valid = v;
    bus.cmp_hit   = h;
    bus.cmp_nonce = n;
    bus.cmp_hash  = hs;
    bus.res_ready = rdy;
    clear         = clr;
    @(negedge clk);
  endtask

  task automatic hit(input logic [31:0] n, input logic rdy);
    step(1'b1, 1'b1, n, mkh(n), rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'h0, 256'h0, rdy, 1'b0);
  endtask

  // Reference model: a queue of pending results and plain saturating integers
  result_t m_q[$];
  int      m_hits = 0;
  int      m_drops = 0;
  bit      m_ovf = 1'b0;

  initial begin
    bit do_pop;
    result_t r;
    forever begin
      @(posedge clk);
      if (!rst_n || clear) begin
        m_q.delete();
        m_hits  = 0;
        m_drops = 0;
        m_ovf   = 1'b0;
      end else begin
        do_pop = (m_q.size() > 0) && (bus.res_ready === 1'b1);
        if (do_pop) void'(m_q.pop_front());
        if (bus.cmp_valid === 1'b1 && bus.cmp_hit === 1'b1) begin
          if (m_hits < CMAX) m_hits++;
          if (m_q.size() >= DEPTH) begin
            if (m_drops < CMAX) m_drops++;
            m_ovf = 1'b1;
          end else begin
            r.nonce = bus.cmp_nonce;
            r.hash  = bus.cmp_hash;
            m_q.push_back(r);
          end
        end
      end
      #1;
      chk("model_valid", 256'(bus.res_valid), 256'(m_q.size() != 0));
      chk("model_level", 256'(res_level), 256'(m_q.size()));
      chk("model_hits", 256'(hit_count), 256'(m_hits));
      chk("model_drops", 256'(drop_count), 256'(m_drops));
      chk("model_ovf", 256'(overflow), 256'(m_ovf));
      if (m_q.size() != 0) begin
        chk("model_nonce", 256'(bus.res_nonce), 256'(m_q[0].nonce));
        chk("model_hash", bus.res_hash, m_q[0].hash);
      end
    end
  end

  initial begin
    // 1: reset held two cycles with a live candidate on the bus
    rst_n = 1'b0;
    step(1'b1, 1'b1, 32'h1234_5678, mkh(32'h1234_5678), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h1234_5678, mkh(32'h1234_5678), 1'b0, 1'b0);
    chk("rst_valid", 256'(bus.res_valid), 256'h0);
    chk("rst_level", 256'(res_level), 256'h0);
    chk("rst_nonce", 256'(bus.res_nonce), 256'h0);
    chk("rst_hash", bus.res_hash, 256'h0);
    chk("rst_hits", 256'(hit_count), 256'h0);
    chk("rst_ovf", 256'(overflow), 256'h0);
    rst_n = 1'b1;

    // 2: single hit, held while the consumer stalls, gone after acceptance
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 256'h1, 1'b0, 1'b0);
    chk("single_valid", 256'(bus.res_valid), 256'h1);
    chk("single_nonce", 256'(bus.res_nonce), 256'hDEAD_BEEF);
    chk("single_hash", bus.res_hash, 256'h1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("single_held", 256'(bus.res_nonce), 256'hDEAD_BEEF);
    idle(1'b1);
    chk("single_popped", 256'(bus.res_valid), 256'h0);
    chk("single_hits", 256'(hit_count), 256'h1);

    // 3: clear with a same-cycle hit, then misses and invalid hits with X payload
    step(1'b1, 1'b1, 32'h77, mkh(32'h77), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(i), mkh(32'(i)), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hx, 256'hx, 1'b0, 1'b0);
    chk("miss_level", 256'(res_level), 256'h0);
    chk("miss_hits", 256'(hit_count), 256'h0);

    // 4: six hits into four slots, then drain in order
    for (int i = 1; i <= 6; i++) hit(32'(i), 1'b0);
    chk("ovf_level", 256'(res_level), 256'h4);
    chk("ovf_drops", 256'(drop_count), 256'h2);
    chk("ovf_hits", 256'(hit_count), 256'h6);
    chk("ovf_flag", 256'(overflow), 256'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 256'(bus.res_nonce), 256'(i));
      idle(1'b1);
    end
    chk("drain_empty", 256'(res_level), 256'h0);

    // 5: push while full and popping is accepted, not dropped
    for (int i = 5; i <= 8; i++) hit(32'(i), 1'b0);
    hit(32'h9, 1'b1);
    chk("fullpp_level", 256'(res_level), 256'h4);
    chk("fullpp_drops", 256'(drop_count), 256'h2);
    for (int i = 6; i <= 9; i++) begin
      chk("fullpp_order", 256'(bus.res_nonce), 256'(i));
      idle(1'b1);
    end

    // 6: hit-counter saturation, clear, drop-counter saturation
    step(1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) hit(32'(100 + i), 1'b1);
    chk("sat_hits", 256'(hit_count), 256'hF);
    chk("sat_level", 256'(res_level), 256'h1);
    step(1'b1, 1'b1, 32'hAA, mkh(32'hAA), 1'b0, 1'b1);
    chk("clr_hits", 256'(hit_count), 256'h0);
    chk("clr_drops", 256'(drop_count), 256'h0);
    chk("clr_level", 256'(res_level), 256'h0);
    chk("clr_valid", 256'(bus.res_valid), 256'h0);
    idle(1'b0);
    chk("clr_not_counted", 256'(hit_count), 256'h0);
    for (int i = 0; i < 24; i++) hit(32'(200 + i), 1'b0);
    chk("satd_drops", 256'(drop_count), 256'hF);
    chk("satd_hits", 256'(hit_count), 256'hF);
    chk("satd_head", 256'(bus.res_nonce), 256'd200);

    // reset during a pending handshake loses the entry
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    chk("midrst_valid", 256'(bus.res_valid), 256'h0);
    chk("midrst_nonce", 256'(bus.res_nonce), 256'h0);

    // mixed traffic, checked only by the model
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
           {8{$urandom()}}, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
